// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and types for the RAM-backed streaming FIFO.
// Imported by the interface, the output queue and the controller.
package ram_pkg;

  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_RAM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int OUTQ_DEPTH    = 2;

  localparam logic [2:0] OUTQ_SLOTS = 3'(OUTQ_DEPTH);

  typedef logic [1:0] outq_cnt_t;

  // Output-queue slots still claimed after this cycle's pop.
  function automatic logic [2:0] slots_busy(
    input outq_cnt_t cnt,
    input logic      inflight,
    input logic      pop
  );
    return {1'b0, cnt}
         + {2'b00, inflight}
         - {2'b00, pop};
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Valid/ready word stream used on both sides
// of the RAM FIFO controller.
interface ram_fifo_ctrl_if
  import ram_pkg::*;
#(
  parameter int DW = DEF_RAM_WIDTH
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/ram_fifo_ctrl_outq.sv
// Two-entry output queue that catches RAM read data;
// slot0 is always the head so the source data is a plain register.
module ram_fifo_outq
  import ram_pkg::*;
#(
  parameter int W = DEF_RAM_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic [W-1:0] enq_data,
  input  logic         deq,
  output logic [W-1:0] head,
  output outq_cnt_t    count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_enq;
  logic         do_deq;

  assign do_deq = deq && (count != 2'd0);
  assign do_enq = enq
               && ((count != 2'd2) || do_deq);
  assign head   = slot0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      unique case ({do_enq, do_deq})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= enq_data;
          end else begin
            slot1 <= enq_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= enq_data;
          end else begin
            slot0 <= slot1;
            slot1 <= enq_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external 1-cycle-latency dual-port RAM,
// with a small output queue to stream at one word per cycle.
module ram_fifo_ctrl
  import ram_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  ram_fifo_ctrl_if.slave       s,
  ram_fifo_ctrl_if.master      m,
  output logic                 ram_wr_enb,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_wr_data,
  output logic                 ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_SIZE:0]   fill_level
);

  localparam logic [ADDR_SIZE:0] FULL =
    (ADDR_SIZE+1)'(RAM_DEPTH);

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE:0]   ram_count;
  logic                 rd_inflight;
  outq_cnt_t            outq_cnt;
  logic [RAM_WIDTH-1:0] outq_head;

  logic s_ready;
  logic m_valid;
  logic push;
  logic pop;
  logic issue;

  // Full is judged on registered state only; a read
  // issued this cycle frees space from the next one.
  assign s_ready = !reset && (ram_count != FULL);
  assign s.ready = s_ready;
  assign push    = s.valid && s_ready;

  assign m_valid = (outq_cnt != 2'd0);
  assign m.valid = m_valid;
  assign m.data  = outq_head;
  assign pop     = m_valid && m.ready;

  // A read may only go out if its return has a
  // queue slot waiting for it next cycle.
  assign issue = !reset
              && (ram_count != '0)
              && (slots_busy(outq_cnt, rd_inflight, pop)
                  < OUTQ_SLOTS);

  assign ram_wr_enb  = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = s.data;
  assign ram_rd_enb  = issue;
  assign ram_rd_addr = rd_ptr;

  assign fill_level = ram_count
                    + {{ADDR_SIZE{1'b0}}, rd_inflight}
                    + (ADDR_SIZE+1)'(outq_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= issue;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, issue})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ;
      endcase
    end
  end

  ram_fifo_outq #(
    .W (RAM_WIDTH)
  ) u_outq (
    .clk      (clk),
    .reset    (reset),
    .enq      (rd_inflight),
    .enq_data (ram_rd_data),
    .deq      (pop),
    .head     (outq_head),
    .count    (outq_cnt)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomised scoreboard bench for ram_fifo_ctrl with a
// behavioural dual-port RAM beside it.
module tb_ram_fifo_ctrl;
  import ram_pkg::*;

  localparam int W  = 8;
  localparam int AW = 8;
  localparam int D  = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DW(W)) s_if ();
  ram_fifo_ctrl_if #(.DW(W)) m_if ();

  logic          ram_wr_enb;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0]  ram_wr_data;
  logic          ram_rd_enb;
  logic [AW-1:0] ram_rd_addr;
  logic [W-1:0]  ram_rd_data;
  logic [AW:0]   fill_level;

  ram_fifo_ctrl #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (D),
    .ADDR_SIZE (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s_if),
    .m           (m_if),
    .ram_wr_enb  (ram_wr_enb),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_enb  (ram_rd_enb),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .fill_level  (fill_level)
  );

  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
  end

  int tests = 0;
  int fails = 0;
  int n_pop = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  // Monitor: the model is simply the ordered list of
  // accepted-but-not-yet-delivered words.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_s_ready", 32'(s_if.ready), 0);
      chk("rst_rd_enb", 32'(ram_rd_enb), 0);
      chk("rst_wr_enb", 32'(ram_wr_enb), 0);
      exp_q.delete();
    end else begin
      chk("fill_level", 32'(fill_level),
          32'(exp_q.size()));
      chk("wr_enb", 32'(ram_wr_enb),
          32'(s_if.valid && s_if.ready));
      if (ram_wr_enb)
        chk("wr_data", 32'(ram_wr_data),
            32'(s_if.data));
      if (m_if.valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_m_valid", 32'(m_if.valid), 0);
        end else begin
          chk("m_data", 32'(m_if.data), 32'(exp_q[0]));
          if (m_if.ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      if (s_if.valid && s_if.ready)
        exp_q.push_back(s_if.data);
    end
  end

  task automatic send(input logic [W-1:0] d);
    logic acc;
    acc = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk);
      acc = s_if.ready;
      @(posedge clk); #1;
    end
    chk("send_accept", 32'(acc), 1);
  endtask

  task automatic drain(input int bound);
    logic done;
    done = 1'b0;
    s_if.valid  = 1'b0;
    m_if.ready  = 1'b1;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clk);
      done = (fill_level == 0) && !m_if.valid;
    end
    chk("drain_done", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t1 [3];
    int words;
    int cyc;
    int pops0;
    t1 = '{8'h11, 8'h22, 8'h33};
    s_if.valid = 1'b0;
    s_if.data  = '0;
    m_if.ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m_valid", 32'(m_if.valid), 0);
    chk("post_rst_fill", 32'(fill_level), 0);
    @(posedge clk); #1;

    // Latency: push at T, first word visible at T+3.
    m_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = t1[i];
      if (i == 2) begin
        @(negedge clk);
        chk("lat_early_m_valid", 32'(m_if.valid), 0);
      end
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    @(negedge clk);
    chk("lat_m_valid", 32'(m_if.valid), 1);
    chk("lat_m_data", 32'(m_if.data), 32'h11);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t1_fill_zero", 32'(fill_level), 0);
    @(posedge clk); #1;

    // Capacity: 256 in RAM plus 2 in the output queue.
    m_if.ready = 1'b0;
    for (int i = 0; i < 258; i++) begin
      if (i < 256) send(W'(i));
      else if (i == 256) send(8'hA0);
      else send(8'hA1);
    end
    s_if.data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_s_ready", 32'(s_if.ready), 0);
      chk("full_fill", 32'(fill_level), 258);
      @(posedge clk); #1;
    end
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("release_rd_enb", 32'(ram_rd_enb), 1);
    chk("release_s_ready_lo", 32'(s_if.ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("release_s_ready_hi", 32'(s_if.ready), 1);
    drain(600);

    // Sustained streaming across pointer wrap.
    m_if.ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = W'($urandom);
      @(negedge clk);
      if (i >= 3)
        chk("stream_m_valid", 32'(m_if.valid), 1);
      chk("stream_s_ready", 32'(s_if.ready), 1);
      @(posedge clk); #1;
    end
    drain(50);

    // Random back-pressure on both sides.
    words = 0;
    cyc = 0;
    while (words < 5000 && cyc < 30000) begin
      s_if.valid = 1'($urandom);
      s_if.data  = W'($urandom);
      m_if.ready = 1'($urandom);
      @(negedge clk);
      if (s_if.valid && s_if.ready) words++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_words", 32'(words >= 5000), 1);
    drain(2000);

    // Reset with data held and a read in flight.
    m_if.ready = 1'b0;
    for (int i = 0; i < 10; i++) send(W'($urandom));
    s_if.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_if.ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_rd_enb", 32'(ram_rd_enb), 1);
    @(posedge clk); #1;
    m_if.ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", 32'(m_if.valid), 0);
    chk("mid_rst_fill", 32'(fill_level), 0);
    @(posedge clk); #1;
    pops0 = n_pop;
    send(8'h5A);
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_pops", 32'(n_pop - pops0), 1);

    // Idle with an empty FIFO.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_rd_enb", 32'(ram_rd_enb), 0);
      chk("idle_m_valid", 32'(m_if.valid), 0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
